// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Types and constants shared by the UART transmitter and receiver.
//            - tx_state_t              : transmit FSM state encoding
//            - c_CLKS_PER_BIT_DEFAULT  : 9600 baud at a 125 MHz clock
//  Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned c_CLKS_PER_BIT_DEFAULT = 13021;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module  : uart_baud_gen
//  Purpose : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; o_bit_tick
//            is high for the single cycle in which the count is at its last
//            value, i.e. the final cycle of a serial bit.
//  Ports   : clk        in  system clock
//            rst        in  synchronous active-high reset
//            i_clear    in  hold the counter at 0 (next bit starts fresh)
//            o_bit_tick out last cycle of the current bit period
//  Revision: 1.0  initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam logic [15:0] c_LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (r_count == c_LAST_CNT) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_bit_tick = (r_count == c_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_tx
//  Purpose : 8N1/8E1/8O1/8x2 UART transmitter with a one-entry holding
//            register in front of the shift register, so a second byte can be
//            accepted while a frame is on the line and sent back-to-back.
//  Ports   : clk        in  system clock
//            rst        in  synchronous active-high reset
//            tx_valid   in  tx_byte holds a byte to send
//            tx_byte    in  byte to send, LSB first
//            tx_ready   out holding register empty
//            tx_serial  out serial line, idle high
//            tx_active  out frame in progress
//            tx_done    out one-cycle pulse at the end of each frame
//  Revision: 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done
);

  localparam logic [2:0] c_LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  r_state;
  logic [7:0] r_hold_data;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_parity;
  logic       r_serial;
  logic       r_active;
  logic       r_done;

  tx_state_t  w_state_nxt;
  logic       w_load;
  logic       w_shift;
  logic [2:0] w_bit_nxt;
  logic       w_serial_nxt;
  logic       w_active_nxt;
  logic       w_done_nxt;
  logic       w_accept;
  logic       w_tick;
  logic       w_parity;

  // Counter is parked at 0 while idle, so the start bit always gets a full
  // period; on back-to-back frames it simply wraps at the stop-bit boundary.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == TX_IDLE),
    .o_bit_tick(w_tick)
  );

  assign w_accept  = tx_valid && !r_hold_full;
  assign w_parity  = (^r_hold_data) ^ (PARITY_ODD != 0);
  assign tx_ready  = !r_hold_full;
  assign tx_serial = r_serial;
  assign tx_active = r_active;
  assign tx_done   = r_done;

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_bit_nxt    = r_bit_cnt;
    w_serial_nxt = r_serial;
    w_active_nxt = r_active;
    w_done_nxt   = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_serial_nxt = 1'b1;
        w_active_nxt = 1'b0;
        if (r_hold_full) begin
          w_state_nxt  = TX_START;
          w_load       = 1'b1;
          w_serial_nxt = 1'b0;
          w_active_nxt = 1'b1;
          w_bit_nxt    = 3'd0;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_state_nxt  = TX_DATA;
          w_serial_nxt = r_shift[0];
          w_shift      = 1'b1;
          w_bit_nxt    = 3'd0;
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == 3'd7) begin
            w_bit_nxt = 3'd0;
            if (PARITY_EN != 0) begin
              w_state_nxt  = TX_PARITY;
              w_serial_nxt = r_parity;
            end else begin
              w_state_nxt  = TX_STOP;
              w_serial_nxt = 1'b1;
            end
          end else begin
            w_serial_nxt = r_shift[0];
            w_shift      = 1'b1;
            w_bit_nxt    = r_bit_cnt + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (w_tick) begin
          w_state_nxt  = TX_STOP;
          w_serial_nxt = 1'b1;
          w_bit_nxt    = 3'd0;
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == c_LAST_STOP) begin
            w_done_nxt = 1'b1;
            w_bit_nxt  = 3'd0;
            // A waiting byte starts its start bit with no idle gap.
            if (r_hold_full) begin
              w_state_nxt  = TX_START;
              w_load       = 1'b1;
              w_serial_nxt = 1'b0;
              w_active_nxt = 1'b1;
            end else begin
              w_state_nxt  = TX_IDLE;
              w_serial_nxt = 1'b1;
              w_active_nxt = 1'b0;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt  = TX_IDLE;
        w_serial_nxt = 1'b1;
        w_active_nxt = 1'b0;
        w_bit_nxt    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_parity    <= 1'b0;
      r_serial    <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_serial  <= w_serial_nxt;
      r_active  <= w_active_nxt;
      r_done    <= w_done_nxt;
      if (w_load) begin
        r_shift  <= r_hold_data;
        r_parity <= w_parity;
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
      // An accept on the same edge as a load wins: the holding register
      // stays full with the new byte while the old one moves to the shifter.
      if (w_accept) begin
        r_hold_data <= tx_byte;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_tx
//  Purpose : Self-checking bench for uart_tx. Four instances cover no parity,
//            even parity, odd parity and two stop bits at 16 clocks per bit.
//            Expected line levels come from the frame rules: start 0, data
//            LSB first, optional parity, stop bits high, each one bit period.
//  Revision: 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] v_valid;
  logic [7:0] v_byte [4];
  logic [3:0] v_ready;
  logic [3:0] v_serial;
  logic [3:0] v_active;
  logic [3:0] v_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(v_valid[0]), .tx_byte(v_byte[0]),
    .tx_ready(v_ready[0]), .tx_serial(v_serial[0]), .tx_active(v_active[0]), .tx_done(v_done[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(v_valid[1]), .tx_byte(v_byte[1]),
    .tx_ready(v_ready[1]), .tx_serial(v_serial[1]), .tx_active(v_active[1]), .tx_done(v_done[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(v_valid[2]), .tx_byte(v_byte[2]),
    .tx_ready(v_ready[2]), .tx_serial(v_serial[2]), .tx_active(v_active[2]), .tx_done(v_done[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .tx_valid(v_valid[3]), .tx_byte(v_byte[3]),
    .tx_ready(v_ready[3]), .tx_serial(v_serial[3]), .tx_active(v_active[3]), .tx_done(v_done[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Level of frame bit i (0 = start) for byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int i, input int par_en, input int odd);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && par_en != 0) return logic'((($countones(b) + odd) % 2) != 0);
    return 1'b1;
  endfunction

  // Send one byte on instance k into an idle transmitter and check the frame.
  task automatic run_frame(input int k, input logic [7:0] b, input int par_en, input int odd, input int stops);
    int nbits;
    int good;
    int bad_act;
    int bad_done;
    nbits    = 1 + 8 + par_en + stops;
    bad_act  = 0;
    bad_done = 0;
    @(negedge clk);
    chk($sformatf("k%0d_ready_idle", k), 32'(v_ready[k]), 32'd1);
    v_valid[k] = 1'b1;
    v_byte[k]  = b;
    @(negedge clk);
    v_valid[k] = 1'b0;
    v_byte[k]  = 8'($urandom);
    chk($sformatf("k%0d_ready_held", k), 32'(v_ready[k]), 32'd0);
    chk($sformatf("k%0d_line_before_start", k), 32'(v_serial[k]), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      good = 0;
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0)
          chk($sformatf("k%0d_ready_after_load", k), 32'(v_ready[k]), 32'd1);
        if (v_serial[k] === exp_bit(b, i, par_en, odd)) good++;
        if (v_active[k] !== 1'b1) bad_act++;
        if (v_done[k] !== 1'b0) bad_done++;
      end
      chk($sformatf("k%0d_b%02h_bit%0d_cycles", k, b, i), 32'(good), 32'(CPB));
    end
    chk($sformatf("k%0d_active_drops_in_frame", k), 32'(bad_act), 32'd0);
    chk($sformatf("k%0d_early_done", k), 32'(bad_done), 32'd0);
    @(negedge clk);
    chk($sformatf("k%0d_done_pulse", k), 32'(v_done[k]), 32'd1);
    chk($sformatf("k%0d_active_end", k), 32'(v_active[k]), 32'd0);
    chk($sformatf("k%0d_line_end", k), 32'(v_serial[k]), 32'd1);
    @(negedge clk);
    chk($sformatf("k%0d_done_one_cycle", k), 32'(v_done[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int bad_line;
    int bad_act;
    int n_done;
    int done_at [$];
    logic [7:0] fb;
    int w;

    // Reset with tx_valid asserted on instance 0: the byte must be ignored.
    rst     = 1'b1;
    v_valid = 4'b0001;
    for (int k = 0; k < 4; k++) v_byte[k] = 8'h3C;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("k%0d_rst_ready", k), 32'(v_ready[k]), 32'd1);
      chk($sformatf("k%0d_rst_line", k), 32'(v_serial[k]), 32'd1);
      chk($sformatf("k%0d_rst_active", k), 32'(v_active[k]), 32'd0);
      chk($sformatf("k%0d_rst_done", k), 32'(v_done[k]), 32'd0);
    end
    rst     = 1'b0;
    v_valid = 4'b0000;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (v_serial[0] !== 1'b1 || v_ready[0] !== 1'b1 || v_active[0] !== 1'b0) bad++;
    end
    chk("valid_ignored_in_reset", 32'(bad), 32'd0);

    // Directed frames.
    run_frame(0, 8'hA5, 0, 0, 1);
    run_frame(1, 8'h07, 1, 0, 1);
    run_frame(2, 8'h07, 1, 1, 1);
    run_frame(3, 8'h3C, 0, 0, 2);

    // Back-to-back: 0x00 then 0xFF with tx_valid held.
    @(negedge clk);
    v_valid[0] = 1'b1;
    v_byte[0]  = 8'h00;
    @(negedge clk);
    chk("b2b_ready_first_held", 32'(v_ready[0]), 32'd0);
    v_byte[0] = 8'hFF;
    bad_line = 0;
    bad_act  = 0;
    n_done   = 0;
    done_at.delete();
    for (int c = 1; c <= 340; c++) begin
      @(negedge clk);
      if (c == 1) chk("b2b_ready_after_load", 32'(v_ready[0]), 32'd1);
      if (c == 2) begin
        chk("b2b_ready_second_held", 32'(v_ready[0]), 32'd0);
        v_valid[0] = 1'b0;
      end
      if (c == 161) chk("b2b_ready_second_loaded", 32'(v_ready[0]), 32'd1);
      if (c <= 320) begin
        fb = (c <= 160) ? 8'h00 : 8'hFF;
        if (v_serial[0] !== exp_bit(fb, ((c - 1) % 160) / CPB, 0, 0)) bad_line++;
        if (v_active[0] !== 1'b1) bad_act++;
      end else begin
        if (v_serial[0] !== 1'b1) bad_line++;
        if (v_active[0] !== 1'b0) bad_act++;
      end
      if (v_done[0] === 1'b1) begin
        n_done++;
        done_at.push_back(c);
      end
    end
    chk("b2b_line_errors", 32'(bad_line), 32'd0);
    chk("b2b_active_errors", 32'(bad_act), 32'd0);
    chk("b2b_done_count", 32'(n_done), 32'd2);
    if (done_at.size() == 2) begin
      chk("b2b_first_done_cycle", 32'(done_at[0]), 32'd161);
      chk("b2b_done_spacing", 32'(done_at[1] - done_at[0]), 32'd160);
    end

    // Reset during D3 of 0x55 with a second byte waiting in hold.
    @(negedge clk);
    v_valid[0] = 1'b1;
    v_byte[0]  = 8'h55;
    @(negedge clk);
    v_byte[0] = 8'h99;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 2) v_valid[0] = 1'b0;
      if (c == 3) chk("rst_mid_second_held", 32'(v_ready[0]), 32'd0);
      if (c == 68) chk("rst_mid_d3_level", 32'(v_serial[0]), 32'(exp_bit(8'h55, 4, 0, 0)));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_line", 32'(v_serial[0]), 32'd1);
    chk("rst_mid_ready", 32'(v_ready[0]), 32'd1);
    chk("rst_mid_active", 32'(v_active[0]), 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (v_serial[0] !== 1'b1 || v_active[0] !== 1'b0 || v_done[0] !== 1'b0) bad++;
    end
    chk("rst_mid_no_more_frames", 32'(bad), 32'd0);

    // Randomized bytes on every configuration.
    for (int n = 0; n < 10; n++) run_frame(0, 8'($urandom), 0, 0, 1);
    for (int n = 0; n < 3; n++) run_frame(1, 8'($urandom), 1, 0, 1);
    for (int n = 0; n < 3; n++) run_frame(2, 8'($urandom), 1, 1, 1);
    for (int n = 0; n < 3; n++) begin
      w = int'($urandom_range(0, 5));
      repeat (w) @(negedge clk);
      run_frame(3, 8'($urandom), 0, 0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 13021, clock cycles per serial bit (9600 baud at 125 MHz); legal range 4..65535.
REQ-002 Parameter PARITY_EN, default 0, 1 inserts a parity bit after D7.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 tx_valid  in  1  tx_byte holds a byte to send.
REQ-008 tx_byte  in  8  byte to send, LSB first.
REQ-009 tx_ready  out  1  holding register empty; byte accepted on an edge where tx_valid && tx_ready.
REQ-010 tx_serial  out  1  serial line; idle high.
REQ-011 tx_active  out  1  frame in progress.
REQ-012 tx_done  out  1  one-cycle pulse at end of each frame.

Function
REQ-013 Datapath: one-entry holding register (hold_data, hold_full) feeding an 8-bit shift register; tx_ready SHALL equal !hold_full (registered, no combinational path from tx_valid).
REQ-014 Accept on edge E: hold_data <= tx_byte, hold_full <= 1; tx_byte is not sampled on any other edge.
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP; IDLE -> START on any edge where hold_full=1.
REQ-016 Entering START: shift register <= hold_data, hold_full <= 0, tx_serial <= 0, tx_active <= 1, bit counter <= 0, baud counter <= 0; first start-bit cycle therefore follows edge E+1 for a byte accepted on edge E while IDLE.
REQ-017 Each of START, each DATA bit, PARITY and each stop bit SHALL drive tx_serial for exactly CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
REQ-018 DATA sends D0..D7 in order; bit counter 0..7; after D7 -> PARITY if PARITY_EN else STOP.
REQ-019 Parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1; computed from the byte at START entry.
REQ-020 STOP drives tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 At end of final stop bit: tx_done=1 for exactly one cycle; if hold_full=1 then -> START on the same edge (no idle cycle, tx_active stays 1), else -> IDLE with tx_active <= 0.
REQ-022 Simultaneous accept and load on one edge: hold_full SHALL remain 1 with the new byte; the loaded byte is the old one; no byte lost or duplicated.
REQ-023 tx_valid deasserted before acceptance has no effect; tx_byte changes while held do not affect a loaded frame.
REQ-024 Illegal FSM encoding SHALL return to IDLE with tx_serial=1 on the next edge.

Reset
REQ-025 rst=1 at an edge SHALL, on that edge, force IDLE, tx_serial=1, tx_active=0, tx_done=0, tx_ready=1, hold_full=0, all counters 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (line high from next cycle); pending held byte discarded.
REQ-027 While rst=1, tx_valid SHALL be ignored.

Structure
REQ-028 Shared package uart_pkg SHALL hold the tx state enum type and the default CLKS_PER_BIT constant (13021), shared with the receiver.
REQ-029 Baud timing SHALL live in sub-module uart_baud_gen (counter with clear input and one-cycle bit_tick output), reusable by the receiver.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-030 Send 0xA5, PARITY_EN=0 -> tx_serial low from edge E+1 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, high 16 cycles, tx_done pulse, frame length 160 cycles.
REQ-031 Hold tx_valid with 0x00 then 0xFF -> second accept while first frame sends, second start bit begins immediately after first stop bit, tx_active never drops, two tx_done pulses 160 cycles apart.
REQ-032 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 176 cycles.
REQ-033 STOP_BITS=2, byte 0x3C -> line high 32 cycles after D7 before tx_done; tx_ready low only while a byte waits in hold.
REQ-034 Assert rst during D3 of 0x55 with a second byte held -> tx_serial=1, tx_ready=1, tx_active=0 next cycle; no further frame sent.
REQ-035 Loopback into uart_rx at CLKS_PER_BIT=13021, 256 random bytes -> every rx_line matches sent byte, one rx_done per tx_done.
